serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial unsigned adder that accepts two WIDTH-bit operands and adds them LSB-first, one bit per clock.
Each bit position is processed by a full-adder slice built from two instances of the team's existing half_adder cell, plus a registered carry.
It is the sequential stage that consumes the half_adder cell. It serves as the lab's multi-bit arithmetic datapath between operand registers and result display/monitor logic.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  sole clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A, captured on the accepted start edge
b  input  WIDTH  operand B, captured on the accepted start edge
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  single-cycle pulse, high when sum/cout become valid
sum  output  WIDTH  result, held stable from done until next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry register and bit counter cleared. Deassertion takes effect at the next rising edge.
- States: IDLE, SHIFT, DONE. Encoding comes from the shared package.
- IDLE: on an edge with start=1:
  - capture a and b into shift registers
  - clear carry, set bit counter to 0, go to SHIFT
  - sum/cout keep their previous values until overwritten
  - start=0 keeps the block in IDLE.
- SHIFT: busy=1. Each edge:
  - first half_adder: a_lsb + b_lsb
  - second half_adder: partial sum + carry register
  - new carry = OR of both half_adder carries
  - result bit shifts into sum MSB-first (sum shifts right, new bit at [WIDTH-1]); operand registers shift right
  - counter increments
- Edge with counter == WIDTH-1: final bit processed, cout <= new carry, go to DONE. sum is complete after this edge.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge E0 -> done high during the cycle after edge E(WIDTH). Throughput: one result per WIDTH+2 cycles max.
- start while in SHIFT or DONE: ignored, no effect on operands or result. Not queued.
- a/b changes after the capture edge: no effect on the current operation.
- Reset mid-operation: the operation is abandoned, all outputs return to reset values immediately, and no done pulse is produced.
- Overflow: sum wraps modulo 2^WIDTH; the true carry appears on cout.
- Unknown/illegal state encoding recovers to IDLE.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - adds input port sub (1 bit), captured with the operands on the accepted start edge
  - sub=1: the b shift register is loaded with ~b and the carry register with 1, producing a - b mod 2^WIDTH; cout=1 means no borrow (a >= b)
  - sub=0: behaviour identical to the undefined build
- Undefined: no sub port; addition only; carry initialised to 0.

Decomposition:
- Shared package serial_adder_pkg:
  - state type/encoding (IDLE, SHIFT, DONE)
  - default WIDTH constant
  - counter width function clog2(WIDTH)
- One sub-module, fa_slice: combinational full adder made of two half_adder instances plus an OR gate, ports a, b, cin, s, cout. This keeps the top-level FSM/datapath clean and reuses the verified half_adder cell.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x01, one-cycle start -> busy high 8 cycles, done pulse once; sum=0x10, cout=0; done exactly 8 cycles after the start edge.
2. a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A -> sum=0xFF, cout=0.
3. start held high continuously with new a/b values applied mid-operation -> first result uses the captured operands only. The next operation is accepted on the edge after DONE (first IDLE cycle); no extra done pulses.
4. rst_n pulsed low at bit 4 of a 0x3C+0x3C addition -> busy/done/sum/cout go to 0 asynchronously with no done pulse. A new start after release gives 0x78, cout=0.
5. Exhaustive sweep of all a, b pairs at WIDTH=4 -> {cout,sum} equals a+b for each; done count equals start count.
6. SERIAL_ADDER_SUB_EN defined, sub=1:
   - a=0x05, b=0x07 -> sum=0xFE, cout=0
   - a=0x07, b=0x05 -> sum=0x02, cout=1
   - sub=0 repeat of scenario 1 matches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default width
// and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell: s = a xor b, c = a and b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_fa_slice.sv
// Combinational full-adder slice (module fa_slice) built from two half_adder
// cells; the two partial carries can never both be 1, so an OR merges them.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p_s;
    logic p_c;
    logic q_c;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (p_s),
        .c (p_c)
    );

    half_adder u_ha1 (
        .a (p_s),
        .b (cin),
        .s (s),
        .c (q_c)
    );

    assign cout = p_c | q_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock through fa_slice.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = clog2(WIDTH);

    // Handshake: start is sampled only in IDLE; the accepting edge captures a/b.
    // done is a one-cycle pulse and sum/cout then hold until the next accepted start.
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               fa_s;
    logic               fa_c;

    fa_slice u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
`ifdef SERIAL_ADDER_SUB_EN
                    // Two's-complement subtract: invert b and inject a carry of 1.
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
`else
                    b_sh_d  = b;
                    carry_d = 1'b0;
`endif
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Status decoded straight from the state so an async reset clears it at once.
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (8-bit and 4-bit instances); exercises
// subtract mode too when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_i;
`endif

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int total;
    int bad;
    int done_cnt;
    int done4_cnt;

    logic [8:0] exp_q[$];

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[6];

    serial_adder #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (done)  done_cnt  <= done_cnt + 1;
        if (done4) done4_cnt <= done4_cnt + 1;
    end

    // Reference: plain arithmetic on the operands.
    function automatic logic [8:0] ref_calc(input logic [7:0] x, input logic [7:0] y, input logic s);
        int r;
        logic [8:0] res;
        if (s) begin
            r = int'(x) - int'(y);
            res = {(x >= y), r[7:0]};
        end else begin
            r = int'(x) + int'(y);
            res = r[8:0];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total = total + 1;
        bad = bad + 1;
        $display("FAIL %s actual=no_done required=done_within_budget", name);
    endtask

    // Called just after the accepting edge; stops at the negedge where done is seen.
    task automatic wait_done8(output int lat, output int busy_n, output bit seen);
        lat = 0;
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n = busy_n + 1;
            @(posedge clk);
            lat = lat + 1;
        end
    endtask

    task automatic finish_op(input string name);
        int lat;
        int busy_n;
        bit seen;
        logic [8:0] exp;
        wait_done8(lat, busy_n, seen);
        exp = exp_q.pop_front();
        if (!seen) begin
            timeout_fail(name);
        end else begin
            check({name, "_lat"}, 32'(lat), 32'd8);
            check({name, "_busy"}, 32'(busy_n), 32'd8);
            check({name, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
            check({name, "_cout"}, {31'd0, cout}, {31'd0, exp[8]});
            @(posedge clk);
            @(negedge clk);
            check({name, "_pulse"}, {31'd0, done}, 32'd0);
            check({name, "_hold"}, {23'd0, cout, sum}, {23'd0, exp});
        end
    endtask

    // driver: one operation, operands scrambled right after capture
    task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb, input logic ts);
        exp_q.push_back(ref_calc(ta, tb, ts));
        @(negedge clk);
        a_i = ta;
        b_i = tb;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_i = 8'($urandom);
        b_i = 8'($urandom);
        finish_op(name);
    endtask

    initial begin
        int dc;
        int lat;
        int busy_n;
        int starts4;
        bit seen;
        logic [7:0] ra;
        logic [7:0] rb;

        total = 0;
        bad = 0;
        done_cnt = 0;
        done4_cnt = 0;
        starts4 = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a_i = 8'h00;
        b_i = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'b0;
`endif
        start4 = 1'b0;
        a4 = 4'h0;
        b4 = 4'h0;

        vecs[0] = '{"v_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[1] = '{"v_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{"v_a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[3] = '{"v_00_00", 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{"v_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[5] = '{"v_80_80", 8'h80, 8'h80, 8'h00, 1'b1};

        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", {30'd0, busy, done}, 32'd0);

        // table-driven vectors with hand-computed results
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].exp_cout, vecs[i].exp_sum});
            @(negedge clk);
            a_i = vecs[i].a;
            b_i = vecs[i].b;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            finish_op(vecs[i].name);
        end

        // randomized operations against the reference model
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op("rand_add", ra, rb, 1'b0);
        end

        // start held high, operands changed mid-operation
        exp_q.push_back(9'h033);
        @(negedge clk);
        a_i = 8'h11;
        b_i = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_i = 8'h77;
        b_i = 8'h66;
        wait_done8(lat, busy_n, seen);
        if (!seen) begin
            timeout_fail("hold_first");
        end else begin
            check("hold_first_lat", 32'(lat), 32'd8);
            check("hold_first_sum", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
            @(posedge clk);
            @(negedge clk);
            check("hold_idle_gap", {30'd0, busy, done}, 32'd0);
            dc = done_cnt;
            exp_q.push_back(9'h0DD);
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done8(lat, busy_n, seen);
            if (!seen) begin
                timeout_fail("hold_second");
            end else begin
                check("hold_second_lat", 32'(lat), 32'd8);
                check("hold_second_sum", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
                @(posedge clk);
                @(negedge clk);
                check("hold_done_count", 32'(done_cnt), 32'(dc + 1));
            end
        end
        start = 1'b0;
        exp_q.delete();

        // reset in the middle of bit 4 of 0x3C + 0x3C
        @(negedge clk);
        a_i = 8'h3C;
        b_i = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_sum", {24'd0, sum}, 32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        dc = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt), 32'(dc));
        do_op("after_rst", 8'h3C, 8'h3C, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_05_07", 8'h05, 8'h07, 1'b1);
        do_op("sub_07_05", 8'h07, 8'h05, 1'b1);
        do_op("sub0_0f_01", 8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op("rand_sub", ra, rb, 1'b1);
        end
`endif

        // exhaustive 4-bit sweep
        dc = done4_cnt;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                a4 = 4'(x);
                b4 = 4'(y);
                start4 = 1'b1;
                @(posedge clk);
                #1;
                start4 = 1'b0;
                starts4 = starts4 + 1;
                seen = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (done4) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) timeout_fail("w4_sweep");
                else check("w4_sum", {27'd0, cout4, sum4}, 32'(x + y));
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("w4_done_count", 32'(done4_cnt - dc), 32'(starts4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
